// File: rtl/cc_frame_scheduler.sv
// C&C frame scheduler: holds four slot payloads, picks one slot per frame
// (dirty slots first, round-robin) and shifts a 59-bit word out MSB first.
//
// state  | meaning
// IDLE   | no frame on the wire, CC_OUT held low
// SHIFT  | bits 58..0 of the latched frame word are being driven
module cc_frame_scheduler #(
  parameter logic [3:0] ADDR_BASE = 4'd0
) (
  input  logic        CBCLK,
  input  logic        reset,
  input  logic        CLRCLK,
  input  logic        PTT,
  input  logic [3:0]  slot_en,
  input  logic        wr_en,
  input  logic [1:0]  wr_slot,
  input  logic [53:0] wr_data,
  output logic        CC_OUT,
  output logic        frame_active,
  output logic [1:0]  cur_slot,
  output logic [3:0]  dirty,
  output logic [3:0]  sent
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic        clr_q, clr_d;
  logic [58:0] sr_q, sr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [53:0] payload_q [4];
  logic [53:0] payload_d [4];
  logic [3:0]  dirty_q, dirty_d;
  logic [3:0]  sent_q, sent_d;
  logic [1:0]  cur_slot_q, cur_slot_d;
  logic [1:0]  last_sel_q, last_sel_d;
  logic        was_dirty_q, was_dirty_d;

  logic        frame_start;
  logic [3:0]  dirty_eff;
  logic [2:0]  dirty_pick;
  logic [2:0]  any_pick;
  logic [1:0]  sel;
  logic [3:0]  addr;

  // Returns {found, index}: first set bit of mask searching from last+1 upward.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + k[1:0];
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // Selection, frame shifting, abort handling and register writes.
  always_comb begin
    state_d     = state_q;
    clr_d       = CLRCLK;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    payload_d   = payload_q;
    dirty_d     = dirty_q;
    sent_d      = 4'b0000;
    cur_slot_d  = cur_slot_q;
    last_sel_d  = last_sel_q;
    was_dirty_d = was_dirty_q;

    frame_start = clr_q & ~CLRCLK;

    // An aborted dirty frame never reached the radio, so it stays pending.
    dirty_eff = dirty_q;
    if (frame_start && (state_q == SHIFT) && was_dirty_q) dirty_eff[cur_slot_q] = 1'b1;

    dirty_pick = rr_pick(dirty_eff & slot_en, last_sel_q);
    any_pick   = rr_pick(slot_en, last_sel_q);
    sel        = dirty_pick[2] ? dirty_pick[1:0] : any_pick[1:0];
    addr       = ADDR_BASE + {2'b00, sel};

    if (state_q == SHIFT) begin
      if (cnt_q == 6'd0) begin
        state_d            = IDLE;
        sent_d[cur_slot_q] = was_dirty_q;
      end else begin
        sr_d  = {sr_q[57:0], 1'b0};
        cnt_d = cnt_q - 6'd1;
      end
    end

    if (frame_start) begin
      sent_d  = 4'b0000;
      dirty_d = dirty_eff;
      if (any_pick[2]) begin
        state_d      = SHIFT;
        sr_d         = {PTT, addr, payload_q[sel]};
        cnt_d        = 6'd58;
        last_sel_d   = sel;
        cur_slot_d   = sel;
        was_dirty_d  = dirty_eff[sel];
        dirty_d[sel] = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end

    // Applied last so a coinciding write keeps its slot pending.
    if (wr_en) begin
      payload_d[wr_slot] = wr_data;
      dirty_d[wr_slot]   = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CBCLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_q       <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      payload_q   <= '{default: '0};
      dirty_q     <= 4'b0000;
      sent_q      <= 4'b0000;
      cur_slot_q  <= 2'd0;
      last_sel_q  <= 2'd3;
      was_dirty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      payload_q   <= payload_d;
      dirty_q     <= dirty_d;
      sent_q      <= sent_d;
      cur_slot_q  <= cur_slot_d;
      last_sel_q  <= last_sel_d;
      was_dirty_q <= was_dirty_d;
    end
  end

  assign frame_active = (state_q == SHIFT);
  assign CC_OUT       = frame_active & sr_q[58];
  assign cur_slot     = cur_slot_q;
  assign dirty        = dirty_q;
  assign sent         = sent_q;

endmodule

// File: tb/tb_cc_frame_scheduler.sv
// Scoreboard bench for cc_frame_scheduler: stimulus pushes expected frames,
// a negedge monitor deserialises CC_OUT and checks each completed frame.
module tb_cc_frame_scheduler;

  logic        CBCLK = 1'b0;
  logic        reset = 1'b1;
  logic        CLRCLK = 1'b0;
  logic        PTT = 1'b1;
  logic [3:0]  slot_en = 4'hF;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_slot = 2'd0;
  logic [53:0] wr_data = '0;
  logic        CC_OUT;
  logic        frame_active;
  logic [1:0]  cur_slot;
  logic [3:0]  dirty;
  logic [3:0]  sent;

  cc_frame_scheduler dut (
    .CBCLK(CBCLK), .reset(reset), .CLRCLK(CLRCLK), .PTT(PTT),
    .slot_en(slot_en), .wr_en(wr_en), .wr_slot(wr_slot), .wr_data(wr_data),
    .CC_OUT(CC_OUT), .frame_active(frame_active), .cur_slot(cur_slot),
    .dirty(dirty), .sent(sent)
  );

  always #5 CBCLK = ~CBCLK;

  typedef struct {
    logic [58:0] word;
    logic [3:0]  snt;
    logic [1:0]  slot;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  localparam logic [53:0] P2 = {32'd14_200_000, 22'h2ABCDE};
  localparam logic [53:0] P1 = 54'h12_3456_789A_BCDE;
  localparam logic [53:0] P3 = 54'h2A_AAAA_5555_0F0F;
  localparam logic [53:0] PA = 54'h15_5555_3333_C3C3;
  localparam logic [53:0] PB = 54'h0F_F0F0_1234_8001;
  localparam logic [53:0] PC = 54'h3F_0000_FFFF_0001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CBCLK);
    #1;
  endtask

  task automatic push(input logic p, input logic [1:0] slot, input logic [53:0] pl,
                      input logic [3:0] snt);
    exp_t e;
    e.word = {p, {2'b00, slot}, pl};
    e.snt  = snt;
    e.slot = slot;
    q.push_back(e);
  endtask

  // CLRCLK high for one cycle, then low; the second edge is the frame start.
  task automatic fire();
    CLRCLK = 1'b1;
    tick(1);
    CLRCLK = 1'b0;
    tick(1);
  endtask

  task automatic write(input logic [1:0] slot, input logic [53:0] d);
    wr_en = 1'b1; wr_slot = slot; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  // Monitor: collect bits while frame_active, check the last 59 on the falling edge.
  logic [58:0] win = '0;
  int          nbits = 0;
  logic        prev_act = 1'b0;
  always @(negedge CBCLK) begin
    exp_t e;
    if (reset) begin
      nbits = 0;
      prev_act = 1'b0;
    end else begin
      if (frame_active) begin
        win = {win[57:0], CC_OUT};
        nbits++;
      end else if (prev_act) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame: got word %0h with no expectation", win);
        end else begin
          e = q.pop_front();
          check("frame_word", {5'd0, win}, {5'd0, e.word});
          check("frame_len_ge59", {63'd0, nbits >= 59}, 64'd1);
          check("sent_pulse", {60'd0, sent}, {60'd0, e.snt});
          check("cur_slot", {62'd0, cur_slot}, {62'd0, e.slot});
        end
        nbits = 0;
      end else begin
        if (sent !== 4'b0000) begin
          total++; bad++;
          $display("FAIL stray_sent: got %0h expected 0", sent);
        end
        if (CC_OUT !== 1'b0) begin
          total++; bad++;
          $display("FAIL idle_cc_out: got %0b expected 0", CC_OUT);
        end
      end
      prev_act = frame_active;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset, with CLRCLK held low across release.
    tick(3);
    check("rst_cc_out", {63'd0, CC_OUT}, 64'd0);
    check("rst_active", {63'd0, frame_active}, 64'd0);
    check("rst_cur_slot", {62'd0, cur_slot}, 64'd0);
    check("rst_dirty", {60'd0, dirty}, 64'd0);
    check("rst_sent", {60'd0, sent}, 64'd0);
    reset = 1'b0;
    tick(5);
    check("low_at_release", {63'd0, frame_active}, 64'd0);

    // Single dirty slot 2 frame.
    write(2'd2, P2);
    check("dirty_after_wr", {60'd0, dirty}, 64'h4);
    push(1'b1, 2'd2, P2, 4'b0100);
    fire();
    tick(60);
    check("dirty_after_f1", {60'd0, dirty}, 64'h0);

    // Refresh walk to last_sel 1, then dirty 1 and 3.
    push(1'b1, 2'd3, '0, 4'b0); fire(); tick(60);
    push(1'b1, 2'd0, '0, 4'b0); fire(); tick(60);
    push(1'b1, 2'd1, '0, 4'b0); fire(); tick(60);
    write(2'd1, P1);
    write(2'd3, P3);
    check("dirty_1_3", {60'd0, dirty}, 64'hA);
    push(1'b1, 2'd3, P3, 4'b1000); fire(); tick(60);
    push(1'b1, 2'd1, P1, 4'b0010); fire(); tick(60);
    push(1'b1, 2'd2, P2, 4'b0); fire(); tick(60);
    push(1'b1, 2'd3, P3, 4'b0); fire(); tick(60);
    push(1'b1, 2'd0, '0, 4'b0); fire(); tick(60);
    push(1'b1, 2'd1, P1, 4'b0); fire(); tick(60);

    // Write coinciding with slot 0 frame start.
    slot_en = 4'b0001;
    write(2'd0, PA);
    push(1'b1, 2'd0, PA, 4'b0001); fire(); tick(60);
    CLRCLK = 1'b1;
    tick(1);
    CLRCLK = 1'b0;
    PTT = 1'b0;
    wr_en = 1'b1; wr_slot = 2'd0; wr_data = PB;
    push(1'b0, 2'd0, PA, 4'b0);
    tick(1);
    wr_en = 1'b0;
    PTT = 1'b1;
    check("dirty_kept_on_collision", {60'd0, dirty}, 64'h1);
    tick(60);
    push(1'b1, 2'd0, PB, 4'b0001); fire(); tick(60);

    // Abort a dirty frame by an early CLRCLK fall.
    slot_en = 4'hF;
    write(2'd1, PC);
    fire();
    tick(28);
    slot_en = 4'b0100;
    push(1'b1, 2'd2, P2, 4'b0);
    fire();
    check("abort_active", {63'd0, frame_active}, 64'd1);
    check("abort_dirty_reset", {60'd0, dirty}, 64'h2);
    tick(60);
    check("abort_dirty_held", {60'd0, dirty}, 64'h2);
    slot_en = 4'hF;
    push(1'b1, 2'd1, PC, 4'b0010); fire(); tick(60);

    // No enabled slots, then only slot 3.
    slot_en = 4'b0000;
    fire();
    for (int i = 0; i < 3; i++) begin
      check("noen_active", {63'd0, frame_active}, 64'd0);
      check("noen_cc_out", {63'd0, CC_OUT}, 64'd0);
      tick(7);
    end
    check("noen_cur_slot", {62'd0, cur_slot}, 64'd1);
    slot_en = 4'b1000;
    push(1'b1, 2'd3, P3, 4'b0); fire(); tick(60);
    push(1'b1, 2'd3, P3, 4'b0); fire(); tick(60);

    // Reset mid-frame.
    slot_en = 4'hF;
    write(2'd2, P1);
    fire();
    tick(20);
    reset = 1'b1;
    #1;
    check("midrst_cc_out", {63'd0, CC_OUT}, 64'd0);
    check("midrst_active", {63'd0, frame_active}, 64'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("postrst_cur_slot", {62'd0, cur_slot}, 64'd0);
    check("postrst_dirty", {60'd0, dirty}, 64'h0);
    check("postrst_sent", {60'd0, sent}, 64'h0);
    check("postrst_active", {63'd0, frame_active}, 64'd0);
    tick(70);
    push(1'b1, 2'd0, '0, 4'b0); fire(); tick(65);

    check("queue_drained", {32'd0, q.size()}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_frame_scheduler.md
CC_FRAME_SCHEDULER -- requirements
Module: cc_frame_scheduler

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 4'd0: slot i is transmitted with address field ADDR_BASE+i (4-bit, wraps mod 16).
REQ-002 SHALL have port CBCLK  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port CLRCLK  input  1  frame strobe, synchronous to CBCLK; a frame starts on its falling edge.
REQ-005 SHALL have port PTT  input  1  global PTT, frame bit 58.
REQ-006 SHALL have port slot_en  input  4  per-slot enable mask.
REQ-007 SHALL have port wr_en  input  1  single-cycle write strobe.
REQ-008 SHALL have port wr_slot  input  2  target slot of a write.
REQ-009 SHALL have port wr_data  input  54  slot payload, frame bits 53:0 (freq[53:22], clk_sel[21:18], OC[17:11], mode[10], PGA[9], DITHER[8], RAND[7], ATTEN[6:5], TX_relay[4:3], Rout[2], RX_relay[1:0]).
REQ-010 SHALL have port CC_OUT  output  1  serial C&C data, MSB first.
REQ-011 SHALL have port frame_active  output  1  high while bits 58..0 are being driven.
REQ-012 SHALL have port cur_slot  output  2  slot of the current or last frame.
REQ-013 SHALL have port dirty  output  4  per-slot pending-update flags.
REQ-014 SHALL have port sent  output  4  one-cycle pulse when a dirty slot's frame completes.

Function
REQ-015 SHALL hold four 54-bit payload registers; wr_en writes wr_data to slot wr_slot and sets dirty[wr_slot] at the same edge.
REQ-016 SHALL detect frame start at the first posedge where CLRCLK is sampled low and was sampled high at the previous posedge (one-flop edge detect).
REQ-017 SHALL, at frame start, select a slot among slot_en: round-robin over enabled dirty slots starting at last_sel+1; if none is dirty, round-robin over enabled slots starting at last_sel+1.
REQ-018 SHALL, at frame start with a selection, latch {PTT, ADDR_BASE+sel, payload[sel]} into a 59-bit shift register, update last_sel and cur_slot, record whether the slot was dirty, and clear dirty[sel].
REQ-019 SHALL drive CC_OUT = bit 58 from the frame-start edge, then bits 57..0 on the following 58 posedges, then 0; frame_active high for exactly those 59 cycles.
REQ-020 SHALL ignore slot_en changes and writes for the frame in progress; payload is that latched at frame start.
REQ-021 SHALL, when a write to slot sel coincides with its frame start, transmit the old payload and leave dirty[sel] set (set wins over clear).
REQ-022 SHALL pulse sent[sel] for one cycle at the cycle after bit 0 is driven, only if the slot was dirty at selection.
REQ-023 SHALL, if a new frame start occurs while frame_active, abort the current frame (no sent pulse), re-set dirty of the aborted slot if it was dirty at selection, then perform a normal selection in the same cycle.
REQ-024 SHALL, when slot_en is 0 at frame start, start no frame: CC_OUT 0, frame_active 0, last_sel unchanged.
REQ-025 SHALL ignore CLRCLK low at reset release until a high-to-low transition is seen.

Reset
REQ-026 SHALL on reset clear: CC_OUT 0, frame_active 0, cur_slot 0, dirty 4'b0, sent 4'b0, payloads 0, shift register 0, last_sel 3 (first choice slot 0), CLRCLK history 1'b0.
REQ-027 SHALL, on reset asserted mid-frame, stop output immediately and emit no sent pulse after release.

Verification
REQ-028 SHALL pass: write slot 2 freq 32'd14_200_000, slot_en 4'hF, PTT 1, one CLRCLK fall -> 59 bits = {1, 4'd2, 32'd14200000, rest}, decoded by a model sampling posedges 1..59 after start; sent 4'b0100 once; dirty 0.
REQ-029 SHALL pass: dirty on slots 1 and 3, last_sel 1 -> next frames select 3 then 1; then with no dirty, refresh order 2,3,0,1.
REQ-030 SHALL pass: write slot 0 on same edge as slot 0 frame start -> old payload sent, no sent pulse clears it, dirty[0] remains 1, next frame sends new data.
REQ-031 SHALL pass: CLRCLK falls again 30 cycles into a dirty-slot frame -> no sent pulse, dirty re-set, new 59-bit frame starts that cycle.
REQ-032 SHALL pass: slot_en 4'b0 -> no frame, CC_OUT 0; slot_en 4'b1000 -> every frame carries address ADDR_BASE+3.
REQ-033 SHALL pass: reset at bit 20 of a frame -> CC_OUT 0 and frame_active 0 during reset, all outputs at REQ-026 values, no sent pulse.
